// File: rtl/gb_mbc3.sv
// gb_mbc3: MBC3 cartridge bank controller for the Game Boy cartridge bus.
// Define MBC3_RTC_EN to include the real-time clock, its prescaler and the latch logic.
module gb_mbc3 #(
  parameter int CLK_HZ = 4194304
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cart_addr,
  input  logic        cart_rd,
  input  logic        cart_wr,
  input  logic [7:0]  cart_di,
  output logic [7:0]  cart_do,
  output logic [20:0] rom_addr,
  input  logic [7:0]  rom_q,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  input  logic [7:0]  ram_q
);
  logic       wr_q, ram_en_q, ram_en_d;
  logic [6:0] rom_bank_q, rom_bank_d;
  logic [3:0] ram_sel_q, ram_sel_d;
  logic [7:0] rtc_rd;
  logic       wr_edge, in_ram, ram_bank_sel, unused;
  assign unused       = ^{cart_rd, cart_di[7]};
  assign wr_edge      = cart_wr & ~wr_q;
  assign in_ram       = cart_addr[15:13] == 3'b101;
  assign ram_bank_sel = ram_sel_q[3:2] == 2'b00;
  assign rom_addr     = {cart_addr[14] ? rom_bank_q : 7'd0, cart_addr[13:0]};
  assign ram_addr     = {ram_sel_q[1:0], cart_addr[12:0]};
  assign ram_we       = cart_wr & in_ram & ram_en_q & ram_bank_sel;
  assign cart_do      = !cart_addr[15] ? rom_q :
                        !(in_ram && ram_en_q) ? 8'hFF :
                        ram_bank_sel ? ram_q : rtc_rd;
  always_comb begin
    ram_en_d   = (wr_edge && cart_addr[15:13] == 3'b000) ? cart_di[3:0] == 4'hA : ram_en_q;
    rom_bank_d = (wr_edge && cart_addr[15:13] == 3'b001) ?
                 (cart_di[6:0] == 7'd0 ? 7'd1 : cart_di[6:0]) : rom_bank_q;
    ram_sel_d  = (wr_edge && cart_addr[15:13] == 3'b010) ? cart_di[3:0] : ram_sel_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q       <= 1'b0;
      ram_en_q   <= 1'b0;
      rom_bank_q <= 7'd1;
      ram_sel_q  <= 4'd0;
    end else begin
      wr_q       <= cart_wr;
      ram_en_q   <= ram_en_d;
      rom_bank_q <= rom_bank_d;
      ram_sel_q  <= ram_sel_d;
    end
  end
`ifdef MBC3_RTC_EN
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  logic [PW-1:0]   pre_q, pre_d;
  logic [5:0]      s_q, s_d, m_q, m_d;
  logic [4:0]      h_q, h_d;
  logic [8:0]      day_q, day_d;
  logic            halt_q, halt_d, dc_q, dc_d, arm_q, arm_d;
  logic [4:0][7:0] lat_q, lat_d, live;
  logic            rtc_sel, rtc_we, latch_wr, tick, s_c, m_c, h_c;
  assign rtc_sel  = ram_sel_q >= 4'h8 && ram_sel_q <= 4'hC;
  assign rtc_we   = wr_edge && in_ram && ram_en_q && rtc_sel;
  assign latch_wr = wr_edge && cart_addr[15:13] == 3'b011;
  assign tick     = !halt_q && pre_q == PW'(CLK_HZ - 1);
  assign s_c      = tick && s_q == 6'd59;
  assign m_c      = s_c && m_q == 6'd59;
  assign h_c      = m_c && h_q == 5'd23;
  assign live     = {dc_q, halt_q, 5'd0, day_q[8], day_q[7:0], 3'd0, h_q, 2'd0, m_q, 2'd0, s_q};
  assign rtc_rd   = rtc_sel ? lat_q[ram_sel_q[2:0]] : 8'hFF;
  // Cascade first, then a same-cycle register write overrides the addressed field.
  always_comb begin
    pre_d  = halt_q ? pre_q : tick ? '0 : pre_q + 1'b1;
    s_d    = !tick ? s_q : (s_q == 6'd59 || s_q == 6'd63) ? 6'd0 : s_q + 6'd1;
    m_d    = !s_c ? m_q : (m_q == 6'd59 || m_q == 6'd63) ? 6'd0 : m_q + 6'd1;
    h_d    = !m_c ? h_q : (h_q == 5'd23 || h_q == 5'd31) ? 5'd0 : h_q + 5'd1;
    day_d  = h_c ? day_q + 9'd1 : day_q;
    dc_d   = dc_q | (h_c && day_q == 9'h1FF);
    halt_d = halt_q;
    if (rtc_we && ram_sel_q == 4'h8) begin
      s_d   = cart_di[5:0];
      pre_d = '0;
    end
    if (rtc_we && ram_sel_q == 4'h9) m_d = cart_di[5:0];
    if (rtc_we && ram_sel_q == 4'hA) h_d = cart_di[4:0];
    if (rtc_we && ram_sel_q == 4'hB) day_d[7:0] = cart_di;
    if (rtc_we && ram_sel_q == 4'hC) begin
      day_d[8] = cart_di[0];
      halt_d   = cart_di[6];
      dc_d     = cart_di[7];
    end
    arm_d = latch_wr ? cart_di == 8'h00 : arm_q;
    lat_d = (latch_wr && arm_q && cart_di == 8'h01) ? live : lat_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q  <= '0;
      s_q    <= 6'd0;
      m_q    <= 6'd0;
      h_q    <= 5'd0;
      day_q  <= 9'd0;
      halt_q <= 1'b0;
      dc_q   <= 1'b0;
      arm_q  <= 1'b0;
      lat_q  <= '0;
    end else begin
      pre_q  <= pre_d;
      s_q    <= s_d;
      m_q    <= m_d;
      h_q    <= h_d;
      day_q  <= day_d;
      halt_q <= halt_d;
      dc_q   <= dc_d;
      arm_q  <= arm_d;
      lat_q  <= lat_d;
    end
  end
`else
  assign rtc_rd = 8'hFF;
`endif
endmodule

// File: doc/gb_mbc3.md
# gb_mbc3

Cartridge-side responder for the Game Boy core's cartridge bus: an MBC3 memory bank controller with optional real-time clock. It sits between the core's `cart_addr/cart_rd/cart_wr/cart_di/cart_do` port and the external ROM/RAM storage. It decodes bank-register writes and generates the physical ROM and RAM addresses. It also returns read data, including latched RTC registers, to the core.

## Interface
Parameters:
- `CLK_HZ`, default 4194304: `clk` frequency in Hz; sets the RTC 1 Hz prescaler.

Ports:
- `clk` in 1: system clock (one clock; all logic on rising edge).
- `reset` in 1: synchronous, active-high.
- `cart_addr` in 16: CPU/DMA address from the core.
- `cart_rd` in 1: read strobe (level).
- `cart_wr` in 1: write strobe (level, may span several cycles).
- `cart_di` in 8: write data from the core.
- `cart_do` out 8: read data to the core (combinational).
- `rom_addr` out 21: physical ROM byte address (2 MB, 128 × 16 KB banks).
- `rom_q` in 8: ROM data for `rom_addr`.
- `ram_addr` out 15: physical cart RAM address (32 KB, 4 × 8 KB banks).
- `ram_we` out 1: cart RAM write enable (level).
- `ram_q` in 8: RAM data for `ram_addr`.

## Operation
Register writes occur only in the first cycle of a `cart_wr` assertion (rising edge of `cart_wr`, registered previous value). Held strobes do not repeat the write.

- 0000–1FFF write: `ram_en` = (`cart_di[3:0]` == 4'hA).
- 2000–3FFF write: `rom_bank` = `cart_di[6:0]`. Value 0 is stored as 1.
- 4000–5FFF write: `ram_sel` = `cart_di[3:0]`.
  - 0–3 selects a RAM bank.
  - 8–C selects RTC S, M, H, DL, DH.
- 6000–7FFF write: latch sequence.
  - Value 00 arms the latch.
  - Value 01 while armed copies live RTC to latched RTC and disarms.
  - Any other value disarms.
- `rom_addr`:
  - `cart_addr[14]` = 0: {7'd0, `cart_addr[13:0]`}.
  - `cart_addr[14]` = 1: {`rom_bank`, `cart_addr[13:0]`}.
- `ram_addr` = {`ram_sel[1:0]`, `cart_addr[12:0]`}.
- `ram_we` = `cart_wr` & A000–BFFF & `ram_en` & `ram_sel` < 4.
- `cart_do`:
  - 0000–7FFF: `rom_q`.
  - A000–BFFF with `ram_en` = 0: FF.
  - A000–BFFF with `ram_sel` 0–3: `ram_q`.
  - A000–BFFF with `ram_sel` 8–C: latched RTC register, unused bits read 0.
  - A000–BFFF with `ram_sel` 4–7 or D–F: FF.
  - Any other address: FF.
- RTC write (A000–BFFF, `ram_en`, `ram_sel` 8–C) targets the live register.
  - Widths: S 6 bits, M 6 bits, H 5 bits, DL 8 bits.
  - DH stores bit0 (day[8]), bit6 (halt) and bit7 (day carry).
  - Writing S also clears the prescaler.
- RTC counting: the prescaler counts 0..`CLK_HZ`-1 while halt = 0. On the terminal count it produces a tick and wraps to 0.
- Tick cascade:
  - S increments. 59→0 carries into M.
  - M increments. 59→0 carries into H.
  - H increments. 23→0 carries into day.
  - Day (9-bit) 511→0 sets carry. Carry is sticky until written 0.
- Out-of-range values (S/M 60–63, H 24–31) increment to their field maximum, then wrap to 0 with no carry.
- Halt = 1 freezes the prescaler and all counters; writes still apply.

## Timing
- Reset values:
  - `rom_bank` = 1, `ram_en` = 0, `ram_sel` = 0, latch disarmed.
  - Live and latched RTC = 0, prescaler = 0.
  - `ram_we` = 0.
  - `cart_do` follows its mux with the reset registers (e.g. FF for A000).
- Register writes take effect the cycle after the `cart_wr` rising edge. `rom_addr`, `ram_addr` and `cart_do` reflect them from that cycle on.
- `rom_addr`, `ram_addr` and `ram_we` are combinational from `cart_addr`/`cart_wr` and the registers; there is no added latency. Read data latency equals the external memory latency.
- Tick and RTC write in the same cycle: the increment cascade applies to all registers, then the addressed register takes the written value.
- Latch and tick in the same cycle: the latched copy receives the pre-increment values.
- Reset asserted mid-write or mid-latch sequence: all state returns to its reset value, and the pending edge detect is cleared.

## Configuration
- `MBC3_RTC_EN` defined: RTC, prescaler and latch logic are present as described.
- `MBC3_RTC_EN` undefined:
  - No RTC state is synthesised.
  - `ram_sel` 8–C reads FF and RTC writes are ignored.
  - 6000–7FFF writes are ignored.
  - Banking is unchanged.

## Test plan
- Reset, then read 4000: `rom_addr` = 0x04000. Write 2000←00, read 4000: `rom_addr` = 0x04000. Write 2000←7F, read 7FFF: `rom_addr` = 0x1FFFFF.
- RAM enable and banking:
  - Read A000 before enable: FF.
  - Write 0000←0A, 4000←02, A123←5C: `ram_we` high with `ram_addr` = 0x4123.
  - Write 0000←00, read A123: FF.
- Hold `cart_wr` 4 cycles on 6000←01 after 6000←00: latch copies exactly once. Sequence 00, 02, 01: no latch.
- With `CLK_HZ`=4:
  - Write S=59, M=59, H=23, DL=FF, DH=01, then run 4 cycles and latch: S=0, M=0, H=0, DL=0, DH=0x80.
  - Write DH=0x00: carry clears.
- With `CLK_HZ`=4: write S=62 and run 8 cycles: S=63, then S=0 with M unchanged. Set DH=0x40, run 100 cycles: counters frozen.
- With `MBC3_RTC_EN` undefined: 4000←08, read A000: FF. RAM bank 0 still writes and reads correctly.
